// File: rtl/generate_sim_pkg.sv
// Shared constants for the generate_sim ripple-carry adder slice.
package generate_sim_pkg;

   localparam int unsigned GENERATE_SIM_DEFAULT_N = 8;

endpackage : generate_sim_pkg

// File: rtl/full_adder.sv
// Single-bit combinational full-adder cell used to build the ripple-carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/generate_sim_rca.sv
// N-bit ripple-carry adder with a registered sum/carry (carry-in tied to 0).
// Optional GENERATE_SIM_OVF_EN adds a registered two's-complement overflow output ovf.
module generate_sim_rca
   import generate_sim_pkg::*;
#(
   parameter int unsigned N = GENERATE_SIM_DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] inA,
   input  logic [N-1:0] inB,
   output logic [N-1:0] sum,
   output logic         carry
`ifdef GENERATE_SIM_OVF_EN
   ,
   output logic         ovf
`endif
);

   logic [N:0]   c;
   logic [N-1:0] s;

   assign c[0] = 1'b0;

   // Cell i consumes c[i] and produces c[i+1].
   for (genvar i = 0; i < N; i++) begin : g_rca
      full_adder u_fa (
         .a    (inA[i]),
         .b    (inB[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         sum   <= s;
         carry <= c[N];
      end
   end

`ifdef GENERATE_SIM_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else begin
         ovf <= c[N] ^ c[N-1];
      end
   end
`endif

endmodule : generate_sim_rca

// File: tb/tb_generate_sim_rca.sv
// Self-checking bench for generate_sim_rca: directed boundary vectors, async reset, random sweep.
// Honours GENERATE_SIM_OVF_EN when the build defines it.
module tb_generate_sim_rca;

   localparam int unsigned N = 8;

   logic         clk;
   logic         rst;
   logic [N-1:0] inA;
   logic [N-1:0] inB;
   logic [N-1:0] sum;
   logic         carry;
`ifdef GENERATE_SIM_OVF_EN
   logic         ovf;
`endif

   int n_checks;
   int n_fail;

   // Expected outputs currently presented by the DUT.
   logic [N-1:0] exp_sum;
   logic         exp_carry;
   logic         exp_ovf;

   generate_sim_rca #(
      .N (N)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .inA   (inA),
      .inB   (inB),
      .sum   (sum),
      .carry (carry)
`ifdef GENERATE_SIM_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference: full-precision unsigned addition and signed range test.
   function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
      longint unsigned r;
      r = longint'(a) + longint'(b);
      return r[N:0];
   endfunction

   function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
      longint sa, sb, r;
      sa = longint'(a) - (a[N-1] ? (longint'(1) << N) : longint'(0));
      sb = longint'(b) - (b[N-1] ? (longint'(1) << N) : longint'(0));
      r  = sa + sb;
      return (r > ((longint'(1) << (N - 1)) - 1)) || (r < -(longint'(1) << (N - 1)));
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".sum"}, 32'(sum), 32'(exp_sum));
      check({tag, ".carry"}, 32'(carry), 32'(exp_carry));
`ifdef GENERATE_SIM_OVF_EN
      check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
   endtask

   // Drive operands between edges, confirm outputs hold, then confirm update after the edge.
   task automatic apply(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0] full;
      @(negedge clk);
      inA = a;
      inB = b;
      #1;
      check_outputs({tag, ".hold"});
      full      = ref_add(a, b);
      @(posedge clk);
      #1;
      exp_sum   = full[N-1:0];
      exp_carry = full[N];
      exp_ovf   = ref_ovf(a, b);
      check_outputs(tag);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      inA       = '0;
      inB       = '0;
      exp_sum   = '0;
      exp_carry = 1'b0;
      exp_ovf   = 1'b0;

      #2;
      check_outputs("reset_init");
      @(posedge clk);
      #1;
      check_outputs("reset_hold");
      @(negedge clk);
      rst = 1'b0;

      apply("zero", 8'h00, 8'h00);
      apply("ba_eb", 8'hBA, 8'hEB);
      check("ba_eb.lit_sum", 32'(sum), 32'h0000_00A5);
      apply("ff_01", 8'hFF, 8'h01);
      apply("7f_01", 8'h7F, 8'h01);
      check("7f_01.lit_sum", 32'(sum), 32'h0000_0080);
      apply("80_80", 8'h80, 8'h80);
      apply("ff_ff", 8'hFF, 8'hFF);

      // Asynchronous reset mid-stream, between edges.
      apply("pre_rst", 8'hBA, 8'hEB);
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_sum   = '0;
      exp_carry = 1'b0;
      exp_ovf   = 1'b0;
      check_outputs("rst_async");
      @(posedge clk);
      #1;
      check_outputs("rst_held");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outputs("rst_release");
      @(posedge clk);
      #1;
      exp_sum   = 8'hA5;
      exp_carry = 1'b1;
      exp_ovf   = ref_ovf(8'hBA, 8'hEB);
      check_outputs("post_rst");

      for (int i = 0; i < 1000; i++) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom);
         rb = N'($urandom);
         apply("rand", ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_generate_sim_rca
